// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and constants for the button debouncer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package debounce_pkg;

   // Width of the per-channel agree counter (holds up to 15 samples).
   localparam int CNT_W = 4;

   // Per-channel debounce state: a stable level, or a pending change toward the other level.
   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      PEND_HIGH   = 2'd1,
      STABLE_HIGH = 2'd2,
      PEND_LOW    = 2'd3
   } deb_state_t;

endpackage : debounce_pkg

// File: rtl/debounce_channel.sv
// debounce_channel: one button channel, accepts a change after STABLE_SAMPLES agreeing ticks.
// Latency: STABLE_SAMPLES ticks from synchronized edge; level and pulse update on the same clk.
// Backpressure: none; press/rel are single-clk strobes, level is a steady output.
// Build option: DEBOUNCE_AUTOREPEAT_EN adds periodic press pulses while the channel stays high.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_SAMPLES = 4,
   parameter int REPEAT_DELAY   = 100,
   parameter int REPEAT_RATE    = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic din,
   output logic level,
   output logic press,
   output logic rel
);

   localparam logic [CNT_W-1:0] SS_LAST = CNT_W'(STABLE_SAMPLES);

   deb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             acc_press, acc_rel;
   logic             rpt_press;
   logic             press_q, rel_q;

   // Next state and agree count; only tick cycles can move the FSM.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_press = 1'b0;
      acc_rel   = 1'b0;
      cnt_inc   = cnt_q + CNT_W'(1);
      if (tick) begin
         case (state_q)
            STABLE_LOW: begin
               if (din) begin
                  state_d = PEND_HIGH;
                  cnt_d   = CNT_W'(1);
               end
            end
            PEND_HIGH: begin
               if (!din) begin
                  state_d = STABLE_LOW;
                  cnt_d   = '0;
               end else if (cnt_inc == SS_LAST) begin
                  state_d   = STABLE_HIGH;
                  cnt_d     = '0;
                  acc_press = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            STABLE_HIGH: begin
               if (!din) begin
                  state_d = PEND_LOW;
                  cnt_d   = CNT_W'(1);
               end
            end
            PEND_LOW: begin
               if (din) begin
                  state_d = STABLE_HIGH;
                  cnt_d   = '0;
               end else if (cnt_inc == SS_LAST) begin
                  state_d = STABLE_LOW;
                  cnt_d   = '0;
                  acc_rel = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = STABLE_LOW;
               cnt_d   = '0;
            end
         endcase
      end
   end

`ifdef DEBOUNCE_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_inc, rpt_target;
   logic             rpt_armed_q, rpt_armed_d;

   // Repeat timing: first wait REPEAT_DELAY ticks, then REPEAT_RATE ticks between presses.
   always_comb begin
      rpt_cnt_d   = rpt_cnt_q;
      rpt_armed_d = rpt_armed_q;
      rpt_press   = 1'b0;
      rpt_inc     = rpt_cnt_q + RPT_W'(1);
      rpt_target  = rpt_armed_q ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DELAY);
      if (state_q != STABLE_HIGH) begin
         rpt_cnt_d   = '0;
         rpt_armed_d = 1'b0;
      end else if (tick) begin
         if (rpt_inc == rpt_target) begin
            rpt_press   = 1'b1;
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b1;
         end else begin
            rpt_cnt_d = rpt_inc;
         end
      end
   end

   // Repeat counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rpt_cnt_q   <= '0;
         rpt_armed_q <= 1'b0;
      end else begin
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_armed_q <= rpt_armed_d;
      end
   end
`else
   // Auto-repeat absent: the always-false expression only keeps the repeat parameters referenced.
   assign rpt_press = (REPEAT_DELAY < 0) && (REPEAT_RATE < 0);
`endif

   // State, agree counter and registered pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= STABLE_LOW;
         cnt_q   <= '0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         press_q <= acc_press | rpt_press;
         rel_q   <= acc_rel;
      end
   end

   // Level is high in STABLE_HIGH and while a release is still pending.
   assign level = (state_q == STABLE_HIGH) || (state_q == PEND_LOW);
   assign press = press_q;
   assign rel   = rel_q;

endmodule : debounce_channel

// File: rtl/button_debouncer.sv
// button_debouncer: N_BTN debounced buttons with a shared sample tick and press/release strobes.
// Latency: 2 clk synchronizer + STABLE_SAMPLES ticks; level and pulse registered together.
// Backpressure: none; outputs are free-running. Build option: DEBOUNCE_AUTOREPEAT_EN (auto-repeat).
module button_debouncer
   import debounce_pkg::*;
#(
   parameter int N_BTN          = 4,
   parameter int TICK_DIV       = 250000,
   parameter int STABLE_SAMPLES = 4,
   parameter int REPEAT_DELAY   = 100,
   parameter int REPEAT_RATE    = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic             tick
);

   localparam int                TICK_W    = $clog2(TICK_DIV);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   logic [N_BTN-1:0]  sync1, sync2;
   logic [TICK_W-1:0] tick_cnt;

   // Two-flop synchronizer on the raw button levels.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_in;
         sync2 <= sync1;
      end
   end

   // Free-running sample divider, 0..TICK_DIV-1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TICK_W'(1);
      end
   end

   assign tick = (tick_cnt == TICK_LAST);

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      debounce_channel #(
         .STABLE_SAMPLES (STABLE_SAMPLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_RATE    (REPEAT_RATE)
      ) u_chan (
         .clk   (clk),
         .reset (reset),
         .tick  (tick),
         .din   (sync2[i]),
         .level (btn_level[i]),
         .press (btn_press[i]),
         .rel   (btn_release[i])
      );
   end

endmodule : button_debouncer
